pipe_stage_reg: RTL and testbench

//  Generic elastic pipeline-stage register for the pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: main + skid buffer, registered in_ready, synchronous flush.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int CTRL_W   = 8,
    parameter int DATA_W   = 128,
    parameter int CLR_DATA = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
);

    logic              main_valid;
    logic              skid_valid;
    logic              in_ready_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;

    logic in_fire;
    logic out_fire;
    logic main_load;
    logic main_take_skid;
    logic main_take_in;
    logic skid_load;
    logic main_valid_next;
    logic skid_valid_next;

    // The skid entry is always older than anything arriving upstream, so it refills main first.
    always_comb begin
        in_fire         = in_valid & in_ready_q;
        out_fire        = main_valid & out_ready;
        main_load       = ~main_valid | out_fire;
        main_take_skid  = main_load & skid_valid;
        main_take_in    = main_load & ~skid_valid & in_fire;
        skid_load       = in_fire & main_valid & ~out_fire;
        main_valid_next = main_load ? (skid_valid | in_fire) : 1'b1;
        skid_valid_next = skid_load | (skid_valid & ~main_load);
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
        end else begin
            main_valid <= main_valid_next;
            skid_valid <= skid_valid_next;
            in_ready_q <= ~skid_valid_next;
            if (main_take_skid)
                main_ctrl <= skid_ctrl;
            else if (main_take_in)
                main_ctrl <= in_ctrl;
            if (skid_load)
                skid_ctrl <= in_ctrl;
        end
    end

    // Payload only needs clearing when CLR_DATA asks for it; otherwise it is a plain enable register.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            if (CLR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            if (main_take_skid)
                main_data <= skid_data;
            else if (main_take_in)
                main_data <= in_data;
            if (skid_load)
                skid_data <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] bubble_q;

    // Counters survive flush on purpose; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (main_valid && !out_ready && (stall_q != 32'hFFFF_FFFF))
                stall_q <= stall_q + 32'd1;
            if (!main_valid && (bubble_q != 32'hFFFF_FFFF))
                bubble_q <= bubble_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus pushes accepted entries, a monitor pops on out_fire.
// Counter expectations follow PIPE_STAGE_PERF_EN when the bench is built with it.
module tb_pipe_stage_reg;

    logic         clk;
    logic         rstn;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_ctrl;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_ctrl;
    logic [127:0] out_data;
    logic [1:0]   occupancy;
    logic [31:0]  stall_cnt;
    logic [31:0]  bubble_cnt;

    int compared   = 0;
    int mismatched = 0;
    logic [135:0] sbQ[$];

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [31:0] EXP_STALL     = 32'd5;
    localparam logic [31:0] EXP_BUBBLE    = 32'd3;
    localparam logic [31:0] EXP_BUBBLE_FL = 32'd4;
`else
    localparam logic [31:0] EXP_STALL     = 32'd0;
    localparam logic [31:0] EXP_BUBBLE    = 32'd0;
    localparam logic [31:0] EXP_BUBBLE_FL = 32'd0;
`endif

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .CLR_DATA(0)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [135:0] act, input logic [135:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every downstream transfer must match the oldest accepted entry.
    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL out_entry: got %0h expected no entry", {out_ctrl, out_data});
                end else begin
                    checkOutput("out_entry", {out_ctrl, out_data}, sbQ.pop_front());
                end
            end else if (!out_valid) begin
                checkOutput("ctrl_gated", 136'(out_ctrl), 136'd0);
            end
        end
    end

    // One clock cycle: drive at edge+1, sample handshake at negedge, return at next edge+1.
    task automatic applyStimulus(input logic v, input logic [7:0] c, input logic [127:0] d,
                                 input logic ordy, input logic fl, output logic acc);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        acc = v && in_ready;
        if (acc && !fl)
            sbQ.push_back({c, d});
        @(posedge clk);
        if (fl)
            sbQ.delete();
        #1;
        flush = 1'b0;
    endtask

    task automatic doReset(input logic fl);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = fl;
        rstn      = 1'b0;
        @(posedge clk);
        sbQ.delete();
        #1;
        rstn  = 1'b1;
        flush = 1'b0;
    endtask

    task automatic checkEmpty(input string name);
        checkOutput({name, "_out_valid"}, 136'(out_valid), 136'd0);
        checkOutput({name, "_out_ctrl"}, 136'(out_ctrl), 136'd0);
        checkOutput({name, "_in_ready"}, 136'(in_ready), 136'd1);
        checkOutput({name, "_occupancy"}, 136'(occupancy), 136'd0);
    endtask

    initial begin
        logic         acc;
        logic         curV;
        logic         curAcc;
        logic [7:0]   curC;
        logic [127:0] curD;
        logic         ordy;
        logic         fl;

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        @(posedge clk);
        #1;

        // Reset state
        doReset(1'b0);
        checkEmpty("reset");
        checkOutput("reset_stall_cnt", 136'(stall_cnt), 136'd0);
        checkOutput("reset_bubble_cnt", 136'(bubble_cnt), 136'd0);

        // Full-rate stream with one-cycle latency
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 8'h80 | 8'(i), 128'(i), 1'b1, 1'b0, acc);
            checkOutput("stream_accept", 136'(acc), 136'd1);
            if (i == 1) begin
                checkOutput("latency_valid", 136'(out_valid), 136'd1);
                checkOutput("latency_data", 136'(out_data), 136'd1);
                checkOutput("latency_occ", 136'(occupancy), 136'd1);
            end
        end
        applyStimulus(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, acc);
        checkOutput("stream_drain_valid", 136'(out_valid), 136'd0);
        checkOutput("stream_drained", 136'(sbQ.size()), 136'd0);

        // Stall: A, B fill both entries, C held upstream until space frees
        applyStimulus(1'b1, 8'h1A, 128'hA, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 8'h1B, 128'hB, 1'b0, 1'b0, acc);
        checkOutput("stall_occ2", 136'(occupancy), 136'd2);
        checkOutput("stall_in_ready", 136'(in_ready), 136'd0);
        applyStimulus(1'b1, 8'h1C, 128'hC, 1'b0, 1'b0, acc);
        checkOutput("stall_c_held", 136'(acc), 136'd0);
        checkOutput("stall_occ_hold", 136'(occupancy), 136'd2);
        applyStimulus(1'b1, 8'h1C, 128'hC, 1'b1, 1'b0, acc);
        checkOutput("stall_c_still_held", 136'(acc), 136'd0);
        checkOutput("stall_occ1", 136'(occupancy), 136'd1);
        checkOutput("stall_ready_back", 136'(in_ready), 136'd1);
        applyStimulus(1'b1, 8'h1C, 128'hC, 1'b1, 1'b0, acc);
        checkOutput("stall_c_accept", 136'(acc), 136'd1);
        applyStimulus(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, acc);
        checkOutput("stall_drained", 136'(sbQ.size()), 136'd0);

        // Flush with both entries full
        applyStimulus(1'b1, 8'h2D, 128'hD, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h2E, 128'hE, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h2F, 128'hF, 1'b0, 1'b1, acc);
        checkEmpty("flush_full");
        // Flush with a same-cycle in_fire and out_fire
        applyStimulus(1'b1, 8'h30, 128'h30, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h31, 128'h31, 1'b1, 1'b1, acc);
        checkOutput("flush_in_fire", 136'(acc), 136'd1);
        checkEmpty("flush_fire");
        applyStimulus(1'b1, 8'h32, 128'h32, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, acc);
        checkOutput("flush_drained", 136'(sbQ.size()), 136'd0);

        // Reset during a stall, with flush also asserted
        applyStimulus(1'b1, 8'h40, 128'h40, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h41, 128'h41, 1'b0, 1'b0, acc);
        doReset(1'b1);
        checkEmpty("reset_mid");
        checkOutput("reset_mid_stall_cnt", 136'(stall_cnt), 136'd0);
        checkOutput("reset_mid_bubble_cnt", 136'(bubble_cnt), 136'd0);

        // Counters: 1 bubble, 5 stalls, 1 transfer, 2 bubbles
        applyStimulus(1'b1, 8'h50, 128'h50, 1'b0, 1'b0, acc);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 8'h00, 128'd0, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 8'h00, 128'd0, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 8'h00, 128'd0, 1'b0, 1'b0, acc);
        checkOutput("perf_stall_cnt", 136'(stall_cnt), 136'(EXP_STALL));
        checkOutput("perf_bubble_cnt", 136'(bubble_cnt), 136'(EXP_BUBBLE));
        // The flush cycle is itself an empty cycle, so it counts as one more bubble
        applyStimulus(1'b0, 8'h00, 128'd0, 1'b0, 1'b1, acc);
        checkOutput("perf_flush_stall_cnt", 136'(stall_cnt), 136'(EXP_STALL));
        checkOutput("perf_flush_bubble_cnt", 136'(bubble_cnt), 136'(EXP_BUBBLE_FL));

        // Random valid/ready with occasional flush; upstream holds an entry until accepted
        curV = 1'b0; curAcc = 1'b1; curC = '0; curD = '0;
        for (int n = 0; n < 10000; n++) begin
            if (!curV || curAcc) begin
                curV = ($urandom_range(0, 3) != 0);
                curC = 8'($urandom);
                curD = {$urandom, $urandom, $urandom, $urandom};
            end
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 99) == 0);
            applyStimulus(curV, curC, curD, ordy, fl, curAcc);
            if (fl)
                curAcc = 1'b1;
        end
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, acc);
        checkOutput("random_drained", 136'(sbQ.size()), 136'd0);
        checkOutput("random_final_occ", 136'(occupancy), 136'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
